// File: rtl/multicore_run_ctrl_pkg.sv
// Shared types and constants for the multicore run coordinator.
package multicore_run_ctrl_pkg;

  localparam int unsigned DEFAULT_CORE_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_FINISH,
    ST_ABORT
  } run_state_t;

endpackage

// File: rtl/multicore_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/multicore_run_ctrl.sv
// Run coordinator: launches a masked subset of cores, gathers their done
// flags, counts RUN cycles and aborts on an optional timeout.
module multicore_run_ctrl
  import multicore_run_ctrl_pkg::*;
#(
  parameter int unsigned CORE_COUNT     = DEFAULT_CORE_COUNT,
  parameter int unsigned CYCLE_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   start,
  input  logic [CORE_COUNT-1:0]  coreMask,
  input  logic [CORE_COUNT-1:0]  coreReady,
  input  logic [CORE_COUNT-1:0]  coreDone,
  output logic [CORE_COUNT-1:0]  coreStart,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [CORE_COUNT-1:0]  doneMask,
  output logic [CYCLE_WIDTH-1:0] cycleCount
);

  localparam logic                   TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LAST = CYCLE_WIDTH'(TIMEOUT_CYCLES - 1);

  run_state_t            state, state_n;
  logic [CORE_COUNT-1:0] active_mask, active_mask_n;
  logic [CORE_COUNT-1:0] done_mask_n, core_start_n, seen_mask;
  logic                  done_n, timeout_n;
  logic                  cnt_clr, cnt_en;
  logic                  mask_ok;

  // A launch needs a non-empty mask whose cores all report ready.
  assign mask_ok = (coreMask != '0) && ((coreReady & coreMask) == coreMask);
  assign ready   = (state == ST_IDLE) && mask_ok;
  assign busy    = (state == ST_LAUNCH) || (state == ST_RUN);

  sat_counter #(
    .WIDTH(CYCLE_WIDTH)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst_n(rstN),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cycleCount)
  );

  always_comb begin
    state_n       = state;
    active_mask_n = active_mask;
    done_mask_n   = doneMask;
    core_start_n  = '0;
    done_n        = 1'b0;
    timeout_n     = timeout;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    seen_mask     = doneMask | (coreDone & active_mask);

    unique case (state)
      ST_IDLE: begin
        if (start && mask_ok) begin
          state_n       = ST_LAUNCH;
          active_mask_n = coreMask;
          done_mask_n   = '0;
          timeout_n     = 1'b0;
          cnt_clr       = 1'b1;
          core_start_n  = coreMask;
        end
      end
      ST_LAUNCH: state_n = ST_RUN;
      ST_RUN: begin
        cnt_en      = 1'b1;
        done_mask_n = seen_mask;
        // Completion takes priority over a timeout landing in the same cycle.
        if (seen_mask == active_mask) begin
          state_n = ST_FINISH;
          done_n  = 1'b1;
        end else if (TIMEOUT_EN && (cycleCount == TIMEOUT_LAST)) begin
          state_n   = ST_ABORT;
          timeout_n = 1'b1;
        end
      end
      ST_FINISH, ST_ABORT: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= ST_IDLE;
      active_mask <= '0;
      doneMask    <= '0;
      coreStart   <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      active_mask <= active_mask_n;
      doneMask    <= done_mask_n;
      coreStart   <= core_start_n;
      done        <= done_n;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// Bench for multicore_run_ctrl: two instances (timeout 10 / 16-bit count, and
// no timeout / 4-bit count) checked against a run-level model every cycle.
module tb_multicore_run_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [3:0] coreMask, coreReady, coreDone;

  logic [3:0]  o_cs [2];
  logic [3:0]  o_dm [2];
  logic        o_ready [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_to [2];
  logic [15:0] o_cc0;
  logic [3:0]  o_cc1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  multicore_run_ctrl #(.CORE_COUNT(4), .CYCLE_WIDTH(16), .TIMEOUT_CYCLES(10)) dut0 (
    .clk(clk), .rstN(rstN), .start(start), .coreMask(coreMask), .coreReady(coreReady),
    .coreDone(coreDone), .coreStart(o_cs[0]), .ready(o_ready[0]), .busy(o_busy[0]),
    .done(o_done[0]), .timeout(o_to[0]), .doneMask(o_dm[0]), .cycleCount(o_cc0));

  multicore_run_ctrl #(.CORE_COUNT(4), .CYCLE_WIDTH(4), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .rstN(rstN), .start(start), .coreMask(coreMask), .coreReady(coreReady),
    .coreDone(coreDone), .coreStart(o_cs[1]), .ready(o_ready[1]), .busy(o_busy[1]),
    .done(o_done[1]), .timeout(o_to[1]), .doneMask(o_dm[1]), .cycleCount(o_cc1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: a run is launched, lives for some number of RUN cycles,
  // then ends in a one-cycle done pulse or a one-cycle abort.
  int unsigned to_lim [2] = '{10, 0};
  int unsigned cmax   [2] = '{65535, 15};
  bit          m_run  [2];
  int          m_age  [2];
  int          m_post [2];   // 1 = done-pulse cycle, 2 = abort cycle
  bit [3:0]    m_act  [2];
  bit [3:0]    m_seen [2];
  int unsigned m_r    [2];   // RUN cycles elapsed, unbounded
  bit          m_to   [2];

  function automatic bit launch_ok();
    return (coreMask != 4'd0) && ((coreReady & coreMask) == coreMask);
  endfunction

  always @(posedge clk or negedge rstN) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstN) begin
        m_run[i] = 1'b0; m_age[i] = 0; m_post[i] = 0; m_act[i] = '0;
        m_seen[i] = '0; m_r[i] = 0; m_to[i] = 1'b0;
      end else if (m_post[i] != 0) begin
        m_post[i] = 0;
      end else if (m_run[i]) begin
        if (m_age[i] == 0) begin
          m_age[i] = 1;
        end else begin
          m_r[i]++;
          m_seen[i] = m_seen[i] | (coreDone & m_act[i]);
          if (m_seen[i] == m_act[i]) begin
            m_run[i] = 1'b0; m_post[i] = 1;
          end else if (to_lim[i] != 0 && m_r[i] == to_lim[i]) begin
            m_run[i] = 1'b0; m_post[i] = 2; m_to[i] = 1'b1;
          end
        end
      end else if (start && launch_ok()) begin
        m_run[i] = 1'b1; m_age[i] = 0; m_act[i] = coreMask;
        m_seen[i] = '0; m_r[i] = 0; m_to[i] = 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit          idle;
        int unsigned exp_cc, act_cc;
        idle   = !m_run[i] && (m_post[i] == 0);
        exp_cc = (m_r[i] > cmax[i]) ? cmax[i] : m_r[i];
        act_cc = (i == 0) ? 32'(o_cc0) : 32'(o_cc1);
        chk($sformatf("d%0d.ready", i), 32'(o_ready[i]), 32'(idle && launch_ok()));
        chk($sformatf("d%0d.busy", i), 32'(o_busy[i]), 32'(m_run[i]));
        chk($sformatf("d%0d.coreStart", i), 32'(o_cs[i]),
            32'((m_run[i] && m_age[i] == 0) ? m_act[i] : 4'd0));
        chk($sformatf("d%0d.done", i), 32'(o_done[i]), 32'(m_post[i] == 1));
        chk($sformatf("d%0d.timeout", i), 32'(o_to[i]), 32'(m_to[i]));
        chk($sformatf("d%0d.doneMask", i), 32'(o_dm[i]), 32'(m_seen[i]));
        chk($sformatf("d%0d.cycleCount", i), act_cc, exp_cc);
      end
      if (o_done[0]) done_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b1; start = 1'b0; coreMask = '0; coreReady = '0; coreDone = '0;
    #2 rstN = 1'b0;
    step(); step();
    rstN = 1'b1;
    chk_en = 1'b1;
    chk("reset.busy", 32'(o_busy[0]), 32'd0);
    chk("reset.cycleCount", 32'(o_cc0), 32'd0);

    // Mask 1011, done on RUN cycles 3, 5, 7.
    done_pulses = 0;
    coreMask = 4'b1011; coreReady = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1.coreStart", 32'(o_cs[0]), 32'hb);
    step();
    for (int n = 1; n <= 7; n++) begin
      coreDone = (n == 3) ? 4'b0001 : (n == 5) ? 4'b0010 : (n == 7) ? 4'b1000 : 4'b0000;
      step();
    end
    coreDone = '0;
    chk("t1.done", 32'(o_done[0]), 32'd1);
    chk("t1.cycleCount", 32'(o_cc0), 32'd7);
    chk("t1.doneMask", 32'(o_dm[0]), 32'hb);
    chk("t1.cycleCount_w4", 32'(o_cc1), 32'd7);
    step(); step();
    chk("t1.done_pulses", 32'(done_pulses), 32'd1);

    // Start held while not all masked cores are ready.
    coreMask = 4'b0110; coreReady = 4'b0100; start = 1'b1;
    step(); step();
    chk("t2.ready_low", 32'(o_ready[0]), 32'd0);
    chk("t2.no_launch", 32'(o_cs[0]), 32'd0);
    coreReady = 4'b1111;
    #1;
    chk("t2.ready_high", 32'(o_ready[0]), 32'd1);
    step();
    start = 1'b0;
    chk("t2.coreStart", 32'(o_cs[0]), 32'h6);
    step();
    coreDone = 4'b0110;
    step();
    coreDone = '0;
    chk("t2.done", 32'(o_done[0]), 32'd1);
    step();

    // Timeout on dut0; dut1 runs on and saturates its 4-bit count.
    coreMask = 4'b0011; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int n = 1; n <= 20; n++) begin
      coreDone = (n == 2) ? 4'b0001 : 4'b0000;
      step();
      if (n == 10) begin
        chk("t3.timeout", 32'(o_to[0]), 32'd1);
        chk("t3.done", 32'(o_done[0]), 32'd0);
        chk("t3.doneMask", 32'(o_dm[0]), 32'h1);
        chk("t3.cycleCount", 32'(o_cc0), 32'd10);
      end
    end
    chk("t3.sat_count", 32'(o_cc1), 32'd15);
    chk("t3.sat_busy", 32'(o_busy[1]), 32'd1);
    chk("t3.timeout_held", 32'(o_to[0]), 32'd1);
    coreDone = 4'b0011;
    step();
    coreDone = '0;
    chk("t3.d1_done", 32'(o_done[1]), 32'd1);
    step();

    // Last core done on RUN cycle 10: done wins over timeout.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4.timeout_cleared", 32'(o_to[0]), 32'd0);
    step();
    for (int n = 1; n <= 10; n++) begin
      coreDone = (n == 1) ? 4'b0001 : (n == 10) ? 4'b0010 : 4'b0000;
      step();
    end
    coreDone = '0;
    chk("t4.done", 32'(o_done[0]), 32'd1);
    chk("t4.timeout", 32'(o_to[0]), 32'd0);
    chk("t4.cycleCount", 32'(o_cc0), 32'd10);
    step();

    // Done during LAUNCH and from an unmasked core is not recorded.
    coreMask = 4'b0001; start = 1'b1;
    step();
    start = 1'b0; coreDone = 4'b0101;
    step();
    coreDone = 4'b0100;
    step();
    chk("t5.doneMask_empty", 32'(o_dm[0]), 32'd0);
    chk("t5.busy", 32'(o_busy[0]), 32'd1);
    coreDone = 4'b0001;
    step();
    coreDone = '0;
    chk("t5.done", 32'(o_done[0]), 32'd1);
    chk("t5.cycleCount", 32'(o_cc0), 32'd2);
    step();

    // Asynchronous reset on RUN cycle 4, then a normal relaunch.
    coreMask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    step();
    coreDone = 4'b0001;
    step();
    coreDone = '0;
    step(); step();
    chk("t6.pre_cycleCount", 32'(o_cc0), 32'd3);
    rstN = 1'b0;
    #1;
    chk("t6.rst_busy", 32'(o_busy[0]), 32'd0);
    chk("t6.rst_doneMask", 32'(o_dm[0]), 32'd0);
    chk("t6.rst_cycleCount", 32'(o_cc0), 32'd0);
    chk("t6.rst_ready", 32'(o_ready[0]), 32'd1);
    step();
    rstN = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0; coreDone = 4'b1111;
    chk("t6.relaunch", 32'(o_cs[0]), 32'hf);
    step(); step();
    coreDone = '0;
    chk("t6.done", 32'(o_done[0]), 32'd1);
    step();

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rstN      = ($urandom_range(0, 149) != 0);
      start     = ($urandom_range(0, 2) == 0);
      coreMask  = 4'($urandom);
      coreReady = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      coreDone  = 4'($urandom) & 4'($urandom);
      step();
    end
    rstN = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicore_run_ctrl.md
# multicore_run_ctrl

Parametrised run coordinator for a cluster of `CORE_COUNT` processor cores.
- Launches a selected subset of cores with a one-cycle start pulse.
- Collects their per-core `done` flags and counts run cycles.
- Aborts on a configurable timeout.
- Sits between the host/testbench start logic and the per-core `start`/`done`/`ready` pins, generalising single-core start/done handshaking to N cores with masking, cycle accounting and timeout detection.

## Interface
Parameters:
- `CORE_COUNT`, 4: number of cores coordinated (≥1).
- `CYCLE_WIDTH`, 16: width of the run-cycle counter.
- `TIMEOUT_CYCLES`, 0: RUN-cycle limit; 0 disables timeout. Must be < 2^`CYCLE_WIDTH`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: sole clock, rising edge.
- `rstN` input 1: asynchronous active-low reset.
- `start` input 1: run request; sampled only while `ready`=1.
- `coreMask` input `CORE_COUNT`: cores to launch; sampled with `start`.
- `coreReady` input `CORE_COUNT`: per-core ready flags.
- `coreDone` input `CORE_COUNT`: per-core done flags (level or pulse).
- `coreStart` output `CORE_COUNT`: per-core start, one-cycle pulse.
- `ready` output 1: a start would be accepted this cycle.
- `busy` output 1: LAUNCH or RUN in progress.
- `done` output 1: one-cycle pulse, all launched cores finished.
- `timeout` output 1: sticky, last run aborted by timeout.
- `doneMask` output `CORE_COUNT`: cores seen done in the current/last run.
- `cycleCount` output `CYCLE_WIDTH`: RUN cycles of the current/last run.

## Operation
- States: IDLE, LAUNCH, RUN, FINISH, ABORT.
- IDLE:
  - `ready` = (`coreMask` != 0) && ((`coreReady` & `coreMask`) == `coreMask`), combinational.
  - `start`=1 with `ready`=1: latch `activeMask`=`coreMask`; clear `doneMask`, `cycleCount` and `timeout`; go to LAUNCH.
  - `start` with `ready`=0 is ignored (no latching, no pending request).
- LAUNCH (1 cycle): `coreStart`=`activeMask`; `coreDone` ignored; go to RUN.
- RUN:
  - `doneMask` |= `coreDone` & `activeMask` (sticky).
  - `cycleCount` increments every RUN cycle, saturating at all-ones.
  - If the next `doneMask` equals `activeMask`, go to FINISH.
  - Otherwise, if `TIMEOUT_CYCLES`≠0 and `cycleCount` == `TIMEOUT_CYCLES`-1, go to ABORT.
- FINISH (1 cycle): `done`=1; go to IDLE.
- ABORT (1 cycle): set `timeout`; go to IDLE; `done` stays 0.
- `doneMask`, `cycleCount` and `timeout` hold their values in IDLE until the next accepted start.
- `busy` = state ∈ {LAUNCH, RUN}. `ready`=0 in every state other than IDLE.
- Done for unmasked cores is ignored in every state. Done during IDLE/LAUNCH is not recorded.
- All-done and timeout in the same RUN cycle: done wins (FINISH, `timeout`=0).
- `cycleCount` saturates and holds when `TIMEOUT_CYCLES`=0 and cores never finish; the run continues indefinitely.
- Reset (any state, mid-run included): state IDLE; all outputs 0 (`ready` then follows its IDLE equation); `activeMask` cleared. Cores in flight are not signalled.

## Timing
- Start accepted at edge k → `coreStart` high during cycle k..k+1 (LAUNCH). RUN begins at edge k+1.
- `cycleCount`=1 after the first RUN cycle.
- Last required `coreDone` sampled at edge t → `done` high for the single cycle after t; `ready` can be 1 one cycle later.
- Minimum start-to-start spacing: 4 cycles (LAUNCH, RUN×1, FINISH, IDLE).
- All state-derived outputs are registered, except `ready` and `busy`, which decode the current state.

## Structure
- Shared package: state enum (IDLE, LAUNCH, RUN, FINISH, ABORT) and a default `CORE_COUNT` constant used by the multicore top level.
- One sub-module, `sat_counter` (`WIDTH`, `clr`, `en`, count output, saturate at max), used for `cycleCount`.
- Everything else stays in one always_ff/always_comb pair.

## Test plan
- `CORE_COUNT`=4, mask 4'b1011, all ready, start. Cores 0, 1, 3 raise done on RUN cycles 3, 5, 7 → `coreStart`=1011 for 1 cycle; `done` pulses once; `cycleCount`=7; `doneMask`=1011.
- Mask 4'b0110 with `coreReady`=4'b0100, start held → `ready`=0, no `coreStart`. Set `coreReady`=1111 → launch the next cycle.
- `TIMEOUT_CYCLES`=10, mask 0011, only core 0 done → ABORT after RUN cycle 10; `timeout`=1; `done` never asserted; `doneMask`=0001.
- `TIMEOUT_CYCLES`=10, last core done on RUN cycle 10 → FINISH, `done`=1, `timeout`=0.
- Unmasked core 2 raises done, plus masked core 0 raises done during LAUNCH → neither recorded. `done` requires the core 0 done in RUN.
- `rstN` low on RUN cycle 4 of a run → all outputs 0 asynchronously. After release, `ready` follows its IDLE equation and a new start launches normally.
